// File: rtl/xy_change_logger_pkg.sv
// Shared types, record layout and width helper for the x/y change logger.
package xy_log_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Bit offsets of the fields inside an event record
  localparam int unsigned REC_C    = 0;
  localparam int unsigned REC_B    = 1;
  localparam int unsigned REC_A    = 2;
  localparam int unsigned REC_Y    = 3;
  localparam int unsigned REC_X    = 4;
  localparam int unsigned REC_CHGY = 5;
  localparam int unsigned REC_CHGX = 6;
  localparam int unsigned REC_TS   = 7;

  typedef struct packed {
    logic x;
    logic y;
    logic a;
    logic b;
    logic c;
  } samp_t;

  function automatic int unsigned rec_w(input int unsigned ts_w);
    return ts_w + 32'd7;
  endfunction

endpackage

// File: rtl/xy_change_logger_if.sv
// Valid/ready record port of the change logger.
interface xy_change_logger_if import xy_log_pkg::*; #(
  parameter int unsigned TS_W = 16
);
  localparam int unsigned W = rec_w(TS_W);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/xy_change_logger_sync_fifo.sv
// Register-array FIFO with first-word fall-through read.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          wr_go_c;
  logic          rd_go_c;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal)
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_go_c = rd_en && !empty;
  assign wr_go_c = wr_en && (!full || rd_go_c);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_go_c);
    rd_ptr_d = rd_ptr_q + PW'(rd_go_c);
    mem_d    = mem_q;
    if (wr_go_c) mem_d[wr_ptr_q[AW-1:0]] = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/xy_change_logger.sv
// Samples a/b/c/x/y each cycle and queues a time-stamped record whenever x or y changes.
module xy_change_logger import xy_log_pkg::*; #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned TS_W   = 16,
  parameter int unsigned DROP_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                a,
  input  logic                b,
  input  logic                c,
  input  logic                x,
  input  logic                y,
  xy_change_logger_if.master  out_if,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_cnt
);
  localparam int unsigned RW = rec_w(TS_W);

  state_e            state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [TS_W-1:0]   s_ts_q, s_ts_d;
  samp_t             s_q, s_d;
  samp_t             p_q, p_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic              event_c, pop_c, wr_c, drop_c;
  logic              full_c, empty_c;
  logic [RW-1:0]     rec_c, rd_data_c;

  // Free-running timestamp and two-deep sample pipeline
  always_comb begin
    ts_d   = ts_q + TS_W'(1);
    s_d    = {x, y, a, b, c};
    s_ts_d = ts_q;
    p_d    = s_q;
  end

  // ARM spends one cycle letting p fill with a real sample before compares count
  always_comb begin
    state_d = state_q;
    event_c = 1'b0;
    unique case (state_q)
      IDLE: if (en) state_d = ARM;
      ARM:  state_d = en ? RUN : IDLE;
      RUN: begin
        event_c = (s_q.x != p_q.x) || (s_q.y != p_q.y);
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rec_c                     = '0;
    rec_c[REC_TS +: TS_W]     = s_ts_q;
    rec_c[REC_CHGX]           = s_q.x ^ p_q.x;
    rec_c[REC_CHGY]           = s_q.y ^ p_q.y;
    rec_c[REC_X:REC_C]        = s_q;
  end

  // A pop in the same cycle frees the slot, so a full FIFO only drops without one
  always_comb begin
    pop_c      = !empty_c && out_if.out_ready;
    wr_c       = event_c && (!full_c || pop_c);
    drop_c     = event_c && full_c && !pop_c;
    overflow_d = overflow_q || drop_c;
    drop_d     = drop_q;
    if (drop_c && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      s_ts_q     <= '0;
      s_q        <= '0;
      p_q        <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      s_ts_q     <= s_ts_d;
      s_q        <= s_d;
      p_q        <= p_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_c),
    .wr_data (rec_c),
    .rd_en   (pop_c),
    .rd_data (rd_data_c),
    .full    (full_c),
    .empty   (empty_c)
  );

  assign out_if.out_valid = !empty_c;
  assign out_if.out_data  = rd_data_c;
  assign overflow         = overflow_q;
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_xy_change_logger.sv
// Scoreboard bench: a 16-bit-timestamp logger with stalls plus a 4-bit-timestamp logger that always drains.
module tb_xy_change_logger;
  import xy_log_pkg::*;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TS_W   = 16;
  localparam int unsigned TS_W4  = 4;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned RW     = rec_w(TS_W);
  localparam int unsigned RW4    = rec_w(TS_W4);

  logic clk = 1'b0;
  logic rst_n, en, a, b, c, x, y;
  logic              ovf_m, ovf_w;
  logic [DROP_W-1:0] dcnt_m, dcnt_w;

  xy_change_logger_if #(.TS_W(TS_W))  m_if ();
  xy_change_logger_if #(.TS_W(TS_W4)) w_if ();

  xy_change_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .DROP_W(DROP_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .x(x), .y(y),
    .out_if(m_if), .overflow(ovf_m), .drop_cnt(dcnt_m)
  );

  xy_change_logger #(.DEPTH(DEPTH), .TS_W(TS_W4), .DROP_W(DROP_W)) u_dut_w4 (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .x(x), .y(y),
    .out_if(w_if), .overflow(ovf_w), .drop_cnt(dcnt_w)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0]  q_m [$];
  logic [RW4-1:0] q_w [$];
  logic [4:0]     cur_v;
  logic [31:0]    edge_idx;

  // Index of the next capturing edge, counted from reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_idx <= '0;
    else        edge_idx <= edge_idx + 32'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // code: 0 no event, 1 event kept by both loggers, 2 event dropped by the stalled logger only
  task automatic step(input logic en_v, input logic rdy, input logic [4:0] v, input int code);
    logic [4:0] chg;
    @(posedge clk);
    #2;
    chg            = v ^ cur_v;
    en             = en_v;
    m_if.out_ready = rdy;
    {x, y, a, b, c} = v;
    if (code == 1) q_m.push_back({edge_idx[TS_W-1:0], chg[4], chg[3], v});
    if (code != 0) q_w.push_back({edge_idx[TS_W4-1:0], chg[4], chg[3], v});
    cur_v = v;
  endtask

  // Monitor for the stalled logger: pops on handshake, checks hold during stalls
  logic          stall_m;
  logic [RW-1:0] stall_d;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_m <= 1'b0;
    end else begin
      if (stall_m) begin
        check("hold_valid", 64'(m_if.out_valid), 64'd1);
        check("hold_data", 64'(m_if.out_data), 64'(stall_d));
      end
      if (m_if.out_valid && m_if.out_ready) begin
        if (q_m.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rec_m: got unexpected record 0x%0h expected none", m_if.out_data);
        end else begin
          check("rec_m", 64'(m_if.out_data), 64'(q_m.pop_front()));
        end
      end
      stall_m <= m_if.out_valid && !m_if.out_ready;
      stall_d <= m_if.out_data;
    end
  end

  // Monitor for the wrapping-timestamp logger (always ready)
  always @(negedge clk) begin
    if (rst_n && w_if.out_valid) begin
      if (q_w.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rec_w: got unexpected record 0x%0h expected none", w_if.out_data);
      end else begin
        check("rec_w", 64'(w_if.out_data), 64'(q_w.pop_front()));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    {x, y, a, b, c} = 5'b0;
    cur_v = 5'b0;
    m_if.out_ready = 1'b1;
    w_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 64'(m_if.out_valid), 64'd0);
    check("rst_data", 64'(m_if.out_data), 64'd0);
    check("rst_ovf", 64'(ovf_m), 64'd0);
    check("rst_drop", 64'(dcnt_m), 64'd0);
    check("rst_valid_w4", 64'(w_if.out_valid), 64'd0);
    rst_n = 1'b1;

    // Counting a/b/c with x=a^b, y=a&b
    step(1, 1, 5'b00_000, 0);
    step(1, 1, 5'b00_000, 0);
    step(1, 1, 5'b00_001, 0);
    step(1, 1, 5'b10_010, 1);
    step(1, 1, 5'b10_011, 0);
    step(1, 1, 5'b10_100, 0);
    step(1, 1, 5'b10_101, 0);
    step(1, 1, 5'b01_110, 1);
    step(1, 1, 5'b01_111, 0);
    step(1, 1, 5'b00_000, 1);

    // Disable, then re-enable while x rises: the ARM cycle must not log
    step(0, 1, 5'b00_000, 0);
    step(0, 1, 5'b00_000, 0);
    step(1, 1, 5'b10_000, 0);
    step(1, 1, 5'b10_000, 0);
    step(1, 1, 5'b10_000, 0);
    step(1, 1, 5'b00_000, 1);
    @(negedge clk);
    @(negedge clk);
    check("lat_capture_edge", 64'(m_if.out_valid), 64'd0);
    @(negedge clk);
    check("lat_write_edge", 64'(m_if.out_valid), 64'd1);

    // Stall: ten toggles into eight slots
    for (int i = 0; i < 10; i++) step(1, 0, cur_v ^ 5'b10_000, (i < 8) ? 1 : 2);
    step(1, 0, cur_v, 0);
    step(1, 0, cur_v, 0);
    check("ovf_after_fill", 64'(ovf_m), 64'd1);
    check("drop_after_fill", 64'(dcnt_m), 64'd2);

    // Full FIFO: event and pop land on the same edge
    step(1, 0, cur_v ^ 5'b10_000, 1);
    step(1, 1, cur_v, 0);
    step(1, 0, cur_v, 0);
    check("drop_simul", 64'(dcnt_m), 64'd2);
    step(1, 0, cur_v ^ 5'b10_000, 2);
    step(1, 0, cur_v, 0);
    step(1, 0, cur_v, 0);
    check("drop_still_full", 64'(dcnt_m), 64'd3);
    check("ovf_sticky", 64'(ovf_m), 64'd1);

    // Drain with alternating stalls
    for (int i = 0; i < 20; i++) step(1, ((i % 2) == 0) ? 1'b1 : 1'b0, cur_v, 0);
    check("drain_q_empty", 64'(q_m.size()), 64'd0);
    check("drain_valid", 64'(m_if.out_valid), 64'd0);

    // x toggling every third cycle; the 4-bit timestamps wrap
    for (int i = 0; i < 21; i++)
      step(1, 1, ((i % 3) == 2) ? (cur_v ^ 5'b10_000) : cur_v, ((i % 3) == 2) ? 1 : 0);

    // Reset mid-drain with records queued
    for (int i = 0; i < 5; i++) step(1, 0, cur_v ^ 5'b10_000, 1);
    step(1, 0, cur_v, 0);
    step(1, 1, cur_v, 0);
    check("ovf_before_rst", 64'(ovf_m), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    {x, y, a, b, c} = 5'b0;
    cur_v = 5'b0;
    q_m.delete();
    q_w.delete();
    #1;
    check("async_valid", 64'(m_if.out_valid), 64'd0);
    check("async_ovf", 64'(ovf_m), 64'd0);
    check("async_drop", 64'(dcnt_m), 64'd0);
    check("async_data", 64'(m_if.out_data), 64'd0);
    check("async_valid_w4", 64'(w_if.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    // First event after release only once IDLE->ARM->RUN has passed
    step(1, 1, 5'b10_000, 0);
    step(1, 1, 5'b00_000, 1);
    step(1, 1, 5'b01_000, 1);
    step(1, 1, 5'b01_000, 0);
    step(1, 1, 5'b01_000, 0);
    step(1, 1, 5'b01_000, 0);
    check("end_q_m_empty", 64'(q_m.size()), 64'd0);
    check("end_q_w_empty", 64'(q_w.size()), 64'd0);
    check("end_ovf", 64'(ovf_m), 64'd0);
    check("end_drop", 64'(dcnt_m), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
